// File: rtl/svc_mem_align.sv
// Byte/half/word load-store aligner in front of a 32-bit zero-latency SRAM port.
// Misaligned accesses are split over two words only when SVC_MEM_ALIGN_SPLIT_EN is defined.
module svc_mem_align #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_rd_addr,
    output logic          mem_rd_valid,
    input  logic [31:0]   mem_rd_data,
    input  logic          mem_rd_data_valid,
    output logic [AW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_data,
    output logic [3:0]    mem_wr_strb,
    output logic          mem_wr_valid,
    output logic          dbg_state
);

    // Handshake: a request transfers on a clk edge where req_valid && req_ready;
    // rsp_valid is a single-cycle pulse, there is no response back-pressure.

`ifdef SVC_MEM_ALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, SECOND} state_t;

    state_t        state, state_n;
    logic [1:0]    offset;
    logic [2:0]    nbytes;
    logic          misaligned;
    logic [63:0]   wvec;
    logic [7:0]    smask;
    logic [AW-1:0] word_addr;
    logic [AW-1:0] next_addr;

    logic          rsp_valid_n, rsp_err_n;
    logic [31:0]   rsp_rdata_n;
    logic          latch_en;

    logic          lat_we, lat_signed, lat_err;
    logic [1:0]    lat_size, lat_offset;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata, lat_first;
    logic [3:0]    lat_strb;

    function automatic logic [31:0] load_fmt(input logic [63:0] v, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sgn);
        logic [63:0] s;
        s = v >> {off, 3'b000};
        case (sz)
            2'd0:    load_fmt = {{24{sgn & s[7]}}, s[7:0]};
            2'd1:    load_fmt = {{16{sgn & s[15]}}, s[15:0]};
            default: load_fmt = s[31:0];
        endcase
    endfunction

    assign offset     = req_addr[1:0];
    assign misaligned = ({1'b0, offset} + nbytes) > 3'd4;
    assign wvec       = {32'b0, req_wdata} << {offset, 3'b000};
    assign word_addr  = {req_addr[AW-1:2], 2'b00};
    assign next_addr  = word_addr + AW'(4);
    assign dbg_state  = (state == SECOND);

    always_comb begin
        nbytes = 3'd4;
        smask  = 8'h0f;
        case (req_size)
            2'd0: begin nbytes = 3'd1; smask = 8'h01 << offset; end
            2'd1: begin nbytes = 3'd2; smask = 8'h03 << offset; end
            default: begin nbytes = 3'd4; smask = 8'h0f << offset; end
        endcase
    end

    always_comb begin
        state_n      = state;
        req_ready    = (state == IDLE) && rst_n;
        mem_rd_addr  = word_addr;
        mem_wr_addr  = word_addr;
        mem_wr_data  = wvec[31:0];
        mem_wr_strb  = smask[3:0];
        mem_rd_valid = 1'b0;
        mem_wr_valid = 1'b0;
        rsp_valid_n  = 1'b0;
        rsp_rdata_n  = 32'b0;
        rsp_err_n    = 1'b0;
        latch_en     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rsp_valid_n = 1'b1;
                    if (req_size == 2'd3 || (misaligned && !SPLIT_EN)) begin
                        rsp_err_n = 1'b1;
                    end else begin
                        mem_wr_valid = req_we;
                        mem_rd_valid = !req_we;
                        if (misaligned) begin
                            // First half now, second word next cycle from latched state.
                            state_n     = SECOND;
                            rsp_valid_n = 1'b0;
                            latch_en    = 1'b1;
                        end else if (!req_we) begin
                            rsp_rdata_n = load_fmt({32'b0, mem_rd_data}, offset, req_size, req_signed);
                            rsp_err_n   = !mem_rd_data_valid;
                        end
                    end
                end
            end
            SECOND: begin
                state_n      = IDLE;
                mem_rd_addr  = lat_addr;
                mem_wr_addr  = lat_addr;
                mem_wr_data  = lat_wdata;
                mem_wr_strb  = lat_strb;
                mem_wr_valid = lat_we;
                mem_rd_valid = !lat_we;
                rsp_valid_n  = 1'b1;
                rsp_err_n    = lat_err | (!lat_we & !mem_rd_data_valid);
                if (!lat_we)
                    rsp_rdata_n = load_fmt({mem_rd_data, lat_first}, lat_offset, lat_size, lat_signed);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_err    <= 1'b0;
            lat_size   <= 2'd0;
            lat_offset <= 2'd0;
            lat_addr   <= '0;
            lat_wdata  <= 32'b0;
            lat_first  <= 32'b0;
            lat_strb   <= 4'b0;
        end else if (latch_en) begin
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_err    <= !req_we & !mem_rd_data_valid;
            lat_size   <= req_size;
            lat_offset <= offset;
            lat_addr   <= next_addr;
            lat_wdata  <= wvec[63:32];
            lat_first  <= mem_rd_data;
            lat_strb   <= smask[7:4];
        end
    end

endmodule

// File: tb/tb_svc_mem_align.sv
// Directed bench for svc_mem_align with a byte-lane SRAM model; covers both
// SVC_MEM_ALIGN_SPLIT_EN builds.
module tb_svc_mem_align;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
    logic        mem_rd_valid, mem_rd_data_valid, mem_wr_valid;
    logic [3:0]  mem_wr_strb;
    logic        dbg_state;

    logic [31:0] mem [0:63];
    logic [31:0] exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    svc_mem_align #(.AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .mem_wr_valid(mem_wr_valid),
        .dbg_state(dbg_state)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency SRAM model
    assign mem_rd_data = mem[mem_rd_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr_valid)
            for (int b = 0; b < 4; b++)
                if (mem_wr_strb[b]) mem[mem_wr_addr[7:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_size   = sz;
        req_signed = sg;
        req_wdata  = wd;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    logic [31:0] b2b_addr [4];
    logic [1:0]  b2b_size [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        //          we    addr      sz    sg    wdata          rd    wr    strb     wr_data        rdata          err
        vecs[0]  = '{1'b1, 32'h00, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 32'h03, 2'd0, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[2]  = '{1'b1, 32'h12, 2'd1, 1'b0, 32'h00005678, 1'b0, 1'b1, 4'b1100, 32'h56780000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h00005678, 1'b0};
        vecs[4]  = '{1'b0, 32'h00, 2'd1, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h01, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h000000BE, 1'b0};
        vecs[6]  = '{1'b0, 32'h00, 2'd2, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 32'h04, 2'd3, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 32'h08, 2'd3, 1'b0, 32'h11111111, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b1, 32'h09, 2'd0, 1'b0, 32'h123456A5, 1'b0, 1'b1, 4'b0010, 32'h3456A500, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 32'h09, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h000000A5, 1'b0};
        vecs[11] = '{1'b0, 32'h09, 2'd0, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[12] = '{1'b0, 32'h02, 2'd1, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[13] = '{1'b0, 32'h02, 2'd1, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000DEAD, 1'b0};

        b2b_addr = '{32'h00, 32'h12, 32'h09, 32'h03};
        b2b_size = '{2'd2, 2'd1, 2'd0, 2'd0};
        b2b_exp  = '{32'hDEADBEEF, 32'h00005678, 32'h000000A5, 32'h000000DE};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
        req_signed = 1'b0; req_wdata = 32'h0; mem_rd_data_valid = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_valid", {30'b0, mem_rd_valid, mem_wr_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

        // Table of single requests
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata);
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
            chk($sformatf("v%0d_rd_valid", i), {31'b0, mem_rd_valid}, {31'b0, vecs[i].exp_rd});
            chk($sformatf("v%0d_wr_valid", i), {31'b0, mem_wr_valid}, {31'b0, vecs[i].exp_wr});
            if (vecs[i].exp_wr) begin
                chk($sformatf("v%0d_strb", i), {28'b0, mem_wr_strb}, {28'b0, vecs[i].exp_strb});
                chk($sformatf("v%0d_wdata", i), mem_wr_data, vecs[i].exp_wdata);
                chk($sformatf("v%0d_wr_addr", i), mem_wr_addr, vecs[i].addr & 32'hFFFFFFFC);
            end
            if (vecs[i].exp_rd)
                chk($sformatf("v%0d_rd_addr", i), mem_rd_addr, vecs[i].addr & 32'hFFFFFFFC);
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("v%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_rsp_err", i), {31'b0, rsp_err}, {31'b0, vecs[i].exp_err});
        end

        // Four back-to-back aligned loads with req_valid held high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b%0d_rsp_valid", i - 1), {31'b0, rsp_valid}, 32'd1);
                chk($sformatf("b2b%0d_rdata", i - 1), rsp_rdata, exp_q.pop_front());
            end
            drive(1'b0, b2b_addr[i], b2b_size[i], 1'b0, 32'h0);
            exp_q.push_back(b2b_exp[i]);
            #1;
            chk($sformatf("b2b%0d_ready", i), {31'b0, req_ready}, 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b3_rdata", rsp_rdata, exp_q.pop_front());
        @(negedge clk);
        chk("b2b_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Load with mem_rd_data_valid low reports an error
        @(negedge clk);
        drive(1'b0, 32'h00, 2'd2, 1'b0, 32'h0);
        mem_rd_data_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_rd_data_valid = 1'b1;
        chk("dv_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("dv_rsp_err", {31'b0, rsp_err}, 32'd1);

`ifdef SVC_MEM_ALIGN_SPLIT_EN
        // Misaligned store word split over 0x20 and 0x24
        @(negedge clk);
        drive(1'b1, 32'h21, 2'd2, 1'b0, 32'hAABBCCDD);
        #1;
        chk("ss_n_wr_valid", {31'b0, mem_wr_valid}, 32'd1);
        chk("ss_n_addr", mem_wr_addr, 32'h20);
        chk("ss_n_strb", {28'b0, mem_wr_strb}, 32'b1110);
        chk("ss_n_wdata", mem_wr_data, 32'hBBCCDD00);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ss_n1_state", {31'b0, dbg_state}, 32'd1);
        chk("ss_n1_ready", {31'b0, req_ready}, 32'd0);
        chk("ss_n1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("ss_n1_wr_valid", {31'b0, mem_wr_valid}, 32'd1);
        chk("ss_n1_addr", mem_wr_addr, 32'h24);
        chk("ss_n1_strb", {28'b0, mem_wr_strb}, 32'b0001);
        chk("ss_n1_wdata", mem_wr_data, 32'h000000AA);
        @(negedge clk);
        chk("ss_n2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ss_n2_rsp_err", {31'b0, rsp_err}, 32'd0);
        // Misaligned load word back
        @(negedge clk);
        drive(1'b0, 32'h21, 2'd2, 1'b0, 32'h0);
        #1;
        chk("sl_n_rd_valid", {31'b0, mem_rd_valid}, 32'd1);
        chk("sl_n_addr", mem_rd_addr, 32'h20);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sl_n1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("sl_n1_addr", mem_rd_addr, 32'h24);
        chk("sl_n1_both", {30'b0, mem_rd_valid, mem_wr_valid}, 32'b10);
        @(negedge clk);
        chk("sl_n2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("sl_n2_rdata", rsp_rdata, 32'hAABBCCDD);
        // Reset while in SECOND drops the split
        @(negedge clk);
        drive(1'b0, 32'h21, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rs_in_second", {31'b0, dbg_state}, 32'd1);
`else
        // Misaligned load is rejected without touching memory
        @(negedge clk);
        drive(1'b0, 32'h21, 2'd2, 1'b0, 32'h0);
        #1;
        chk("ml_rd_valid", {31'b0, mem_rd_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ml_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ml_rsp_err", {31'b0, rsp_err}, 32'd1);
        chk("ml_rsp_rdata", rsp_rdata, 32'd0);
        // Reset with a response pending drops it
        @(negedge clk);
        drive(1'b0, 32'h04, 2'd3, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rs_ready", {31'b0, req_ready}, 32'd0);
        chk("rs_mem_valid", {30'b0, mem_rd_valid, mem_wr_valid}, 32'd0);
        chk("rs_state", {31'b0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rs_hold_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rs_rel_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("rs_rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
